rob_dispatch_arbiter: RTL and testbench
=======================================

# rob_dispatch_arbiter

Two-requester, round-robin dispatch arbiter in front of the reorder buffer's single dispatch port. Each requester (decode lane 0 / lane 1) presents one micro-op per cycle with a valid/ready handshake. The arbiter grants one requester per cycle into a one-entry output register. That register drives the ROB's `valid / typ / dst` inputs and honours the ROB's busy back-pressure. The block also provides a flush and per-lane grant statistics.

## Interface
Parameters:
- `TYP_W`, 2, width of the micro-op type field
- `DST_W`, 2, width of the destination field
- `CNT_W`, 8, width of each saturating grant counter

Ports:
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_rst`  in  1  reset; synchronous, active-high
- `i_req0_valid`  in  1  lane 0 has a micro-op
- `i_req0_typ`  in  TYP_W  lane 0 type
- `i_req0_dst`  in  DST_W  lane 0 destination
- `o_req0_ready`  out  1  lane 0 micro-op accepted this cycle
- `i_req1_valid`, `i_req1_typ`, `i_req1_dst`, `o_req1_ready`  same as lane 0, for lane 1
- `o_dq_valid`  out  1  output register holds a micro-op for the ROB
- `o_dq_typ`  out  TYP_W  type to ROB
- `o_dq_dst`  out  DST_W  destination to ROB
- `i_dq_busy`  in  1  ROB cannot accept this cycle
- `i_flush`  in  1  discard the held micro-op and suppress grants this cycle
- `o_last_grant`  out  1  lane that received the most recent grant
- `o_grant_cnt0`  out  CNT_W  saturating count of lane 0 grants
- `o_grant_cnt1`  out  CNT_W  saturating count of lane 1 grants

## Operation
- **ROB transfer:** a transfer occurs in any cycle with `o_dq_valid & ~i_dq_busy`.
- **Load enable:** `load_ok = ~i_flush & (~o_dq_valid | ~i_dq_busy)`.
- **Grant selection** (only when `load_ok`):
  - Only one lane valid: that lane is granted.
  - Both lanes valid: the lane `~o_last_grant` is granted.
  - Neither lane valid: no grant.
- **Ready outputs:** `o_reqK_ready = grantK`. They are combinational from the valids, `i_dq_busy`, `i_flush` and state. At most one ready is high per cycle.
- **On a grant to lane K:**
  - The output register loads `typ` and `dst` from lane K.
  - `o_dq_valid` becomes 1.
  - `o_last_grant` becomes K.
  - `o_grant_cntK` increments, saturating at 2^CNT_W-1 (no wrap).
- **Transfer with no grant:** `o_dq_valid` becomes 0. `o_dq_typ` and `o_dq_dst` hold their last values.
- **Busy, no transfer:** `o_dq_valid`, `o_dq_typ` and `o_dq_dst` hold stable. Payload must not change while valid and busy.
- **Flush:**
  - Next cycle `o_dq_valid` = 0.
  - Both readies are 0 during the flush cycle.
  - `o_last_grant` and the counters are unchanged.
  - Flush has priority over load and hold.
  - The ROB may still see a transfer in the flush cycle if `o_dq_valid & ~i_dq_busy`. That transfer is legal; the entry then counts as dispatched.
- **Reset values:**
  - `o_dq_valid`=0, `o_dq_typ`=0, `o_dq_dst`=0.
  - `o_last_grant`=1, so lane 0 wins the first tie.
  - `o_grant_cnt0`=`o_grant_cnt1`=0.
  - Readies are 0 while `i_rst` is high.
- **Reset mid-operation:** any held micro-op is dropped; no grant is issued during a reset cycle.

## Timing
- **Latency:** 1 cycle from a requester handshake (valid & ready high at edge N) to `o_dq_valid` with that payload after edge N.
- **Throughput:** one micro-op per cycle while `i_dq_busy`=0. A transfer and a new load in the same cycle give back-to-back dispatch with no bubble.
- **Alternation:** with both lanes continuously valid and the ROB never busy, grants alternate 0,1,0,1,...
- **Back-pressure:** while `i_dq_busy`=1 with `o_dq_valid`=1, both readies stay 0 and the arbitration pointer does not move.
- **Starvation bound:** a valid lane waits at most one grant to the other lane.
- **Counters:** counter and pointer updates are visible the cycle after the grant.

## Test plan
- **Reset:** assert `i_rst` for 2 cycles with both lanes valid -> readies 0. After release, `o_dq_valid`=0, counts 0, `o_last_grant`=1.
- **Tie and alternation:** both lanes valid for 4 cycles with distinct `dst` (lane0 `dst`=1, lane1 `dst`=2), `i_dq_busy`=0 -> ready pattern 0,1,0,1. `o_dq_dst` one cycle later reads 1,2,1,2. Both counts end at 2.
- **Back-pressure:** load lane0 `typ`=3, then hold `i_dq_busy`=1 for 3 cycles with lane1 valid:
  - During busy: `o_dq_typ` stays 3 and `o_req1_ready`=0.
  - Cycle busy drops: `o_req1_ready`=1.
  - Next cycle: `o_dq_valid`=1 with lane1's payload.
- **Flush:** `o_dq_valid`=1, `i_dq_busy`=1, assert `i_flush` for 1 cycle with lane0 valid -> `o_req0_ready`=0. Next cycle `o_dq_valid`=0; the pointer and counts are unchanged.
- **Saturation:** lane0 alone valid for 260 cycles, ROB never busy -> `o_grant_cnt0`=255 (no wrap), `o_grant_cnt1`=0.
- **Single lane:** lane1 alone valid after `o_last_grant`=1 -> lane1 granted immediately each cycle (no tie-breaking penalty).

Source files
------------

// File: rtl/rob_dispatch_arbiter.sv
// rob_dispatch_arbiter: two-lane round-robin arbiter feeding a one-entry ROB dispatch register
// with flush and saturating per-lane grant counters.
module rob_dispatch_arbiter #(
    parameter int TYP_W = 2,
    parameter int DST_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    input  logic [TYP_W-1:0] i_req0_typ,
    input  logic [DST_W-1:0] i_req0_dst,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [TYP_W-1:0] i_req1_typ,
    input  logic [DST_W-1:0] i_req1_dst,
    output logic             o_req1_ready,
    output logic             o_dq_valid,
    output logic [TYP_W-1:0] o_dq_typ,
    output logic [DST_W-1:0] o_dq_dst,
    input  logic             i_dq_busy,
    input  logic             i_flush,
    output logic             o_last_grant,
    output logic [CNT_W-1:0] o_grant_cnt0,
    output logic [CNT_W-1:0] o_grant_cnt1
);
    logic             valid_q, valid_d, last_q, last_d;
    logic [TYP_W-1:0] typ_q, typ_d;
    logic [DST_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             load_ok, g0, g1;

    // Reset gates grants so no handshake is reported during a reset cycle.
    assign load_ok = ~i_rst & ~i_flush & (~valid_q | ~i_dq_busy);
    assign g0 = load_ok & i_req0_valid & (~i_req1_valid | last_q);
    assign g1 = load_ok & i_req1_valid & (~i_req0_valid | ~last_q);

    always_comb begin
        valid_d = i_flush ? 1'b0 : (g0 | g1) ? 1'b1 : (valid_q & ~i_dq_busy) ? 1'b0 : valid_q;
        typ_d   = g0 ? i_req0_typ : g1 ? i_req1_typ : typ_q;
        dst_d   = g0 ? i_req0_dst : g1 ? i_req1_dst : dst_q;
        last_d  = g0 ? 1'b0 : g1 ? 1'b1 : last_q;
        cnt0_d  = (g0 && cnt0_q != '1) ? cnt0_q + 1'b1 : cnt0_q;
        cnt1_d  = (g1 && cnt1_q != '1) ? cnt1_q + 1'b1 : cnt1_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            typ_q   <= '0;
            dst_q   <= '0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            valid_q <= valid_d;
            typ_q   <= typ_d;
            dst_q   <= dst_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign o_req0_ready = g0;
    assign o_req1_ready = g1;
    assign o_dq_valid   = valid_q;
    assign o_dq_typ     = typ_q;
    assign o_dq_dst     = dst_q;
    assign o_last_grant = last_q;
    assign o_grant_cnt0 = cnt0_q;
    assign o_grant_cnt1 = cnt1_q;
endmodule

// File: tb/tb_rob_dispatch_arbiter.sv
// tb_rob_dispatch_arbiter: directed bench for the ROB dispatch arbiter.
module tb_rob_dispatch_arbiter;
    logic       clk = 1'b0, rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, busy = 1'b0, flush = 1'b0;
    logic [1:0] t0 = '0, d0 = '0, t1 = '0, d1 = '0;
    logic       r0, r1, dq_valid, last_grant;
    logic [1:0] dq_typ, dq_dst;
    logic [7:0] cnt0, cnt1;
    int total = 0, bad = 0;

    rob_dispatch_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_typ(t0), .i_req0_dst(d0), .o_req0_ready(r0),
        .i_req1_valid(v1), .i_req1_typ(t1), .i_req1_dst(d1), .o_req1_ready(r1),
        .o_dq_valid(dq_valid), .o_dq_typ(dq_typ), .o_dq_dst(dq_dst), .i_dq_busy(busy),
        .i_flush(flush), .o_last_grant(last_grant),
        .o_grant_cnt0(cnt0), .o_grant_cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; readies are sampled at the falling edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mid;
            chk("rst_r0", r0, 0);
            chk("rst_r1", r1, 0);
            tick;
        end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        mid;
        chk("rst_valid", dq_valid, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_last", last_grant, 1);
        chk("rst_typ", dq_typ, 0);
        tick;

        v0 = 1'b1; d0 = 2'd1; t0 = 2'd0;
        v1 = 1'b1; d1 = 2'd2; t1 = 2'd1;
        for (int i = 0; i < 4; i++) begin
            mid;
            chk("alt_r0", r0, (i % 2 == 0) ? 1 : 0);
            chk("alt_r1", r1, (i % 2 == 0) ? 0 : 1);
            tick;
            chk("alt_valid", dq_valid, 1);
            chk("alt_dst", dq_dst, (i % 2 == 0) ? 1 : 2);
            chk("alt_last", last_grant, i % 2);
        end
        chk("alt_cnt0", cnt0, 2);
        chk("alt_cnt1", cnt1, 2);

        v1 = 1'b0; t0 = 2'd3; d0 = 2'd0;
        mid;
        chk("bp_load_r0", r0, 1);
        tick;
        chk("bp_typ0", dq_typ, 3);
        chk("bp_last0", last_grant, 0);
        v0 = 1'b0; v1 = 1'b1; t1 = 2'd1; d1 = 2'd3; busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid;
            chk("bp_r1_busy", r1, 0);
            chk("bp_typ_hold", dq_typ, 3);
            chk("bp_valid_hold", dq_valid, 1);
            tick;
        end
        chk("bp_last_hold", last_grant, 0);
        busy = 1'b0;
        mid;
        chk("bp_r1_release", r1, 1);
        tick;
        chk("bp_valid1", dq_valid, 1);
        chk("bp_typ1", dq_typ, 1);
        chk("bp_dst1", dq_dst, 3);
        chk("bp_cnt0", cnt0, 3);
        chk("bp_cnt1", cnt1, 3);

        v1 = 1'b0; v0 = 1'b1; busy = 1'b1; flush = 1'b1;
        mid;
        chk("fl_r0", r0, 0);
        chk("fl_r1", r1, 0);
        tick;
        chk("fl_valid", dq_valid, 0);
        chk("fl_last", last_grant, 1);
        chk("fl_cnt0", cnt0, 3);
        chk("fl_cnt1", cnt1, 3);
        flush = 1'b0; busy = 1'b0; v0 = 1'b0;

        v1 = 1'b1; t1 = 2'd2; d1 = 2'd1;
        for (int i = 0; i < 3; i++) begin
            mid;
            chk("sl_r1", r1, 1);
            tick;
            chk("sl_cnt1", cnt1, 4 + i);
        end
        v1 = 1'b0;
        tick;
        chk("drain_valid", dq_valid, 0);
        chk("drain_dst_hold", dq_dst, 1);

        v0 = 1'b1; t0 = 2'd2; d0 = 2'd2;
        for (int i = 0; i < 260; i++) tick;
        chk("sat_cnt0", cnt0, 255);
        chk("sat_cnt1", cnt1, 6);
        chk("sat_valid", dq_valid, 1);

        rst = 1'b1;
        mid;
        chk("mrst_r0", r0, 0);
        tick;
        chk("mrst_valid", dq_valid, 0);
        chk("mrst_cnt0", cnt0, 0);
        chk("mrst_last", last_grant, 1);
        rst = 1'b0; v0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
